intt_scheduler: RTL and testbench



---
 rtl/intt_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/intt_scheduler.sv | 164 ++++++++++++++++
 tb/tb_intt_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_sched_pkg.sv
// Shared types and sizing helpers for the INTT processor scheduler.
// Exports: state_t, err_t, LOG_N, out_beats().
package intt_sched_pkg;

  localparam int LOG_N = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE    = 2'd0,
    E_TIMEOUT = 2'd1,
    E_TRUNC   = 2'd2,
    E_ADDR    = 2'd3
  } err_t;

  function automatic int out_beats(input int log_core_count);
    return 1 << (LOG_N - 2 - log_core_count);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered pointer.
// Ports: clk, rst, req_i, enable_i, adv_i/adv_idx_i in; gnt_o, gnt_idx_o out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       enable_i,
  input  logic                       adv_i,
  input  logic [$clog2(NUM_REQ)-1:0] adv_idx_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   sum_c;
  logic [IW-1:0] idx_c;
  logic          found_c;

  // Scan from the pointer upward, wrapping at NUM_REQ.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found_c   = 1'b0;
    sum_c     = '0;
    idx_c     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_c = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum_c >= (IW+1)'(NUM_REQ))
        sum_c = sum_c - (IW+1)'(NUM_REQ);
      idx_c = sum_c[IW-1:0];
      if (enable_i && !found_c && req_i[idx_c]) begin
        found_c      = 1'b1;
        gnt_o[idx_c] = 1'b1;
        gnt_idx_o    = idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else if (adv_i)
      ptr_q <= (adv_idx_i == IW'(NUM_REQ-1)) ?
               '0 : adv_idx_i + 1'b1;
  end

endmodule

// File: rtl/intt_scheduler.sv
// Shares one intt_processor among NUM_REQ requesters with a watchdog.
// Ports: req/gnt/done per requester, intt_* to the core, out_*, busy, err*.
module intt_scheduler
  import intt_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LOG_CORE_COUNT = 4,
  parameter int OUT_BEATS      = out_beats(LOG_CORE_COUNT),
  parameter int TIMEOUT        = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       intt_start,
  input  logic                       intt_output_active,
  input  logic [8:0]                 intt_address_out,
  output logic                       out_valid,
  output logic [$clog2(NUM_REQ)-1:0] out_owner,
  output logic                       busy,
  output logic                       err,
  output logic [1:0]                 err_code,
  input  logic                       err_clear
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT+1);
  localparam int BW = $clog2(OUT_BEATS+1);

  state_t             state_q, state_d;
  err_t               code_q, code_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [WW-1:0]      wd_q, wd_d, wd_inc;
  logic [BW-1:0]      beat_q, beat_d;
  logic               start_q, start_d;
  logic               ov_q, ov_d;
  logic [OW-1:0]      oo_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [OW-1:0]      arb_idx;
  logic               adv;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .enable_i (state_q == S_IDLE),
    .adv_i    (adv),
    .adv_idx_i(owner_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx)
  );

  assign wd_inc = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    beat_d  = beat_q;
    start_d = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (intt_output_active) begin
          beat_d  = BW'(1);
          state_d = S_DRAIN;
        end else if (wd_inc == WW'(TIMEOUT)) begin
          gnt_d   = '0;
          code_d  = E_TIMEOUT;
          state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        if (!intt_output_active) begin
          gnt_d   = '0;
          code_d  = E_TRUNC;
          state_d = S_ERR;
        end else if (intt_address_out != 9'(beat_q)) begin
          gnt_d   = '0;
          code_d  = E_ADDR;
          state_d = S_ERR;
        end else begin
          beat_d = beat_q + 1'b1;
          if (beat_q + 1'b1 == BW'(OUT_BEATS)) begin
            gnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        adv     = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clear) begin
          adv     = 1'b1;
          code_d  = E_NONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first beat lands while still in WAIT, so it is forwarded too.
  assign ov_d = intt_output_active &&
                (state_q == S_WAIT || state_q == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= E_NONE;
      gnt_q   <= '0;
      owner_q <= '0;
      wd_q    <= '0;
      beat_q  <= '0;
      start_q <= 1'b0;
      ov_q    <= 1'b0;
      oo_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      oo_q    <= ov_d ? owner_q : '0;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == S_DONE)
      done[owner_q] = 1'b1;
  end

  assign gnt        = gnt_q;
  assign intt_start = start_q;
  assign out_valid  = ov_q;
  assign out_owner  = oo_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err        = (state_q == S_ERR);
  assign err_code   = code_q;

endmodule

// File: tb/tb_intt_scheduler.sv
// Directed bench for intt_scheduler with a hand-driven processor model.
// Ports: drives req/err_clear/intt_*; checks gnt/done/start/out_*/err*.
module tb_intt_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       intt_start;
  logic       act = 1'b0;
  logic [8:0] addr = '0;
  logic       out_valid;
  logic [1:0] out_owner;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic       err_clear = 1'b0;

  int total = 0;
  int bad   = 0;

  intt_scheduler #(
    .NUM_REQ(4),
    .LOG_CORE_COUNT(4),
    .OUT_BEATS(64),
    .TIMEOUT(100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .gnt               (gnt),
    .done              (done),
    .intt_start        (intt_start),
    .intt_output_active(act),
    .intt_address_out  (addr),
    .out_valid         (out_valid),
    .out_owner         (out_owner),
    .busy              (busy),
    .err               (err),
    .err_code          (err_code),
    .err_clear         (err_clear)
  );

  always #5 clk = ~clk;

  task automatic drive_beats(input int first, input int n,
                             input int badi, input int own,
                             output int nv, output int no);
    nv = 0;
    no = 0;
    for (int i = 0; i < n; i++) begin
      act  = 1'b1;
      addr = 9'((first + i == badi) ? first + i + 1 : first + i);
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (out_owner !== 2'(own)) no++;
      end
    end
    act  = 1'b0;
    addr = '0;
  endtask

  task automatic wait_gnt(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (gnt == '0 && c < 10);
  endtask

  task automatic wait_start();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!intt_start && c < 10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt, done, intt_start, out_valid, out_owner} !== 12'h0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=0",
               {gnt, done, intt_start, out_valid, out_owner});
    end
    total++;
    if ({busy, err, err_code} !== 4'h0) begin
      bad++;
      $display("FAIL reset_stat got=%h exp=0", {busy, err, err_code});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int nv, no;
    req = 4'b0010;
    @(negedge clk);
    total++;
    if ({gnt, intt_start, busy} !== {4'b0010, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL single_gnt got=%b exp=%b",
               {gnt, intt_start, busy}, 6'b001001);
    end
    @(negedge clk);
    total++;
    if (intt_start !== 1'b1) begin
      bad++;
      $display("FAIL single_start got=%b exp=1", intt_start);
    end
    @(negedge clk);
    total++;
    if (intt_start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_len got=%b exp=0", intt_start);
    end
    drive_beats(0, 64, -1, 1, nv, no);
    total++;
    if ({done, gnt, err} !== {4'b0010, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL single_done got=%b exp=%b",
               {done, gnt, err}, 9'b001000000);
    end
    total++;
    if (nv !== 64 || no !== 0) begin
      bad++;
      $display("FAIL single_beats got=%0d/%0d exp=64/0", nv, no);
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if ({done, busy} !== 5'b0) begin
      bad++;
      $display("FAIL single_idle got=%b exp=0", {done, busy});
    end
  endtask

  task automatic test_back_to_back();
    int nv, no, c;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(c);
      total++;
      if (gnt !== 4'(1 << j)) begin
        bad++;
        $display("FAIL b2b_gnt%0d got=%b exp=%b", j, gnt, 4'(1 << j));
      end
      if (j > 0) begin
        total++;
        if (c !== 2) begin
          bad++;
          $display("FAIL b2b_gap%0d got=%0d exp=2", j, c);
        end
      end
      wait_start();
      drive_beats(0, 64, -1, j, nv, no);
      total++;
      if (done !== 4'(1 << j) || nv !== 64 || no !== 0) begin
        bad++;
        $display("FAIL b2b_done%0d got=%b/%0d/%0d exp=%b/64/0",
                 j, done, nv, no, 4'(1 << j));
      end
      req[j] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int nv, no, c;
    req = 4'b0001;
    wait_gnt(c);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL to_gnt got=%b exp=0001", gnt);
    end
    wait_start();
    repeat (99) @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b exp=0", err);
    end
    @(negedge clk);
    total++;
    if ({err, err_code, gnt, busy, done} !== {3'b101, 9'b0}) begin
      bad++;
      $display("FAIL to_err got=%b exp=%b",
               {err, err_code, gnt, busy, done}, {3'b101, 9'b0});
    end
    req = 4'b0011;
    repeat (3) @(negedge clk);
    total++;
    if ({err, gnt} !== 5'b10000) begin
      bad++;
      $display("FAIL to_sticky got=%b exp=10000", {err, gnt});
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    total++;
    if ({err, err_code, gnt} !== 7'b0) begin
      bad++;
      $display("FAIL to_clear got=%b exp=0", {err, err_code, gnt});
    end
    wait_gnt(c);
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL to_skip got=%b exp=0010", gnt);
    end
    wait_start();
    drive_beats(0, 64, -1, 1, nv, no);
    total++;
    if (done !== 4'b0010) begin
      bad++;
      $display("FAIL to_next_done got=%b exp=0010", done);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_truncated();
    int nv, no, c;
    req = 4'b0100;
    wait_gnt(c);
    wait_start();
    drive_beats(0, 40, -1, 2, nv, no);
    total++;
    if (nv !== 40 || done !== 4'b0) begin
      bad++;
      $display("FAIL tr_beats got=%0d/%b exp=40/0000", nv, done);
    end
    @(negedge clk);
    total++;
    if ({err, err_code, done, gnt} !== {3'b110, 8'b0}) begin
      bad++;
      $display("FAIL tr_err got=%b exp=%b",
               {err, err_code, done, gnt}, {3'b110, 8'b0});
    end
    req = 4'b0000;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic test_addr_glitch();
    int nv, no, c;
    req = 4'b1000;
    wait_gnt(c);
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL ad_gnt got=%b exp=1000", gnt);
    end
    wait_start();
    drive_beats(0, 12, 10, 3, nv, no);
    total++;
    if ({err, err_code, done, gnt} !== {3'b111, 8'b0}) begin
      bad++;
      $display("FAIL ad_err got=%b exp=%b",
               {err, err_code, done, gnt}, {3'b111, 8'b0});
    end
    req = 4'b0000;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nv, no, c;
    req = 4'b0001;
    wait_gnt(c);
    wait_start();
    drive_beats(0, 30, -1, 0, nv, no);
    act  = 1'b1;
    addr = 9'd30;
    rst  = 1'b1;
    #1;
    total++;
    if ({gnt, done, intt_start, out_valid, busy, err} !== 12'h0) begin
      bad++;
      $display("FAIL rm_out got=%b exp=0",
               {gnt, done, intt_start, out_valid, busy, err});
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    drive_beats(31, 33, -1, 0, nv, no);
    total++;
    if (nv !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rm_drain got=%0d/%b exp=0/0", nv, busy);
    end
    req = 4'b0001;
    wait_gnt(c);
    total++;
    if (gnt !== 4'b0001 || c !== 1) begin
      bad++;
      $display("FAIL rm_regnt got=%b/%0d exp=0001/1", gnt, c);
    end
    wait_start();
    drive_beats(0, 64, -1, 0, nv, no);
    total++;
    if (done !== 4'b0001 || nv !== 64) begin
      bad++;
      $display("FAIL rm_done got=%b/%0d exp=0001/64", done, nv);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_truncated();
    test_addr_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
